vga_timing: RTL and testbench

Generates the 640x480@60 Hz VGA raster for the wirecube renderer: horizontal/vertical counters, pixel coordinates, display-enable, sync pulses and line/frame strobes. Sits directly upstream of the pixel shading logic inside `wirecube_top`. Its `hsync_o`, `vsync_o`, `next_vertical_o` and `next_frame_o` are the signals the top level routes to the Tiny VGA PMOD and to the renderer. It runs on the 25.175 MHz pixel clock, one pixel per cycle.

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/vga_timing_if.sv | 27 ++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing.sv | 89 ++++++++
 tb/tb_vga_timing.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
// The optional frame counter is enabled by defining VGA_TIMING_FRAME_CNT_EN.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int FRAME_CNT_W  = 8;

endpackage

// File: rtl/vga_timing_if.sv
// Raster output bundle from vga_timing to the shading logic and the VGA PMOD.
// frame_o exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if;
  import vga_timing_pkg::*;

  coord_t x_o;
  coord_t y_o;
  logic   de_o;
  logic   hsync_o;
  logic   vsync_o;
  logic   next_vertical_o;
  logic   next_frame_o;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_o;

  modport master (output x_o, y_o, de_o, hsync_o, vsync_o,
                  next_vertical_o, next_frame_o, frame_o);
  modport slave  (input  x_o, y_o, de_o, hsync_o, vsync_o,
                  next_vertical_o, next_frame_o, frame_o);
`else
  modport master (output x_o, y_o, de_o, hsync_o, vsync_o,
                  next_vertical_o, next_frame_o);
  modport slave  (input  x_o, y_o, de_o, hsync_o, vsync_o,
                  next_vertical_o, next_frame_o);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap-around counter with sync/active/last decodes.
// Flags are decoded from the next count so they register alongside it.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK,
  parameter bit POL    = 1'b0
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  output coord_t count_o,
  output logic   sync_o,
  output logic   last_o,
  output logic   active_nxt_o,
  output logic   last_nxt_o
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  if (TOTAL > 1024) begin : g_total_check
    $error("vga_axis_counter: total %0d exceeds 1024", TOTAL);
  end

  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END  = coord_t'(ACTIVE);
  localparam coord_t SYNC_BEG = coord_t'(ACTIVE + FRONT);
  localparam coord_t SYNC_END = coord_t'(ACTIVE + FRONT + SYNC - 1);

  coord_t count_nxt;
  logic   sync_nxt;

  always_comb begin
    count_nxt = count_o;
    if (en_i) begin
      count_nxt = (count_o == LAST) ? '0 : count_o + coord_t'(1);
    end
    sync_nxt     = (count_nxt >= SYNC_BEG && count_nxt <= SYNC_END) ? POL : ~POL;
    active_nxt_o = (count_nxt < ACT_END);
    last_nxt_o   = (count_nxt == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
      sync_o  <= ~POL;
      last_o  <= 1'b0;
    end else begin
      count_o <= count_nxt;
      sync_o  <= sync_nxt;
      last_o  <= last_nxt_o;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 VGA raster generator: coordinates, display enable, syncs, strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_o counter.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  vga_timing_if.master vga
);

  coord_t h_count, v_count;
  logic   h_sync, v_sync;
  logic   h_last, unused_v_last;
  logic   h_active_nxt, v_active_nxt;
  logic   h_last_nxt, v_last_nxt;
  logic   de_q, next_frame_q;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_SYNC_POL)
  ) u_h_axis (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (1'b1),
    .count_o      (h_count),
    .sync_o       (h_sync),
    .last_o       (h_last),
    .active_nxt_o (h_active_nxt),
    .last_nxt_o   (h_last_nxt)
  );

  // The vertical axis steps on the same edge that wraps the horizontal one.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_SYNC_POL)
  ) u_v_axis (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (h_last),
    .count_o      (v_count),
    .sync_o       (v_sync),
    .last_o       (unused_v_last),
    .active_nxt_o (v_active_nxt),
    .last_nxt_o   (v_last_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_q         <= 1'b1;
      next_frame_q <= 1'b0;
    end else begin
      de_q         <= h_active_nxt & v_active_nxt;
      next_frame_q <= h_last_nxt & v_last_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_q;

  // next_frame_q marks the last cycle, so the increment lands on pixel (0,0).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q <= '0;
    end else if (next_frame_q) begin
      frame_q <= frame_q + FRAME_CNT_W'(1);
    end
  end

  assign vga.frame_o = frame_q;
`endif

  assign vga.x_o             = h_count;
  assign vga.y_o             = v_count;
  assign vga.de_o            = de_q;
  assign vga.hsync_o         = h_sync;
  assign vga.vsync_o         = v_sync;
  assign vga.next_vertical_o = h_last;
  assign vga.next_frame_o    = next_frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three parameter sets checked every cycle against a
// coordinate-level model, with directed run-length, reset and wrap checks.
`timescale 1ns/1ps
module tb_vga_timing;
  import vga_timing_pkg::*;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit HAS_FRAME = 1'b1;
`else
  localparam bit HAS_FRAME = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [3];

  vga_timing_if vif0 ();
  vga_timing_if vif1 ();
  vga_timing_if vif2 ();

  vga_timing d0 (.clk_i(clk), .rst_i(rst[0]), .vga(vif0));

  vga_timing #(
    .H_ACTIVE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
  ) d1 (.clk_i(clk), .rst_i(rst[1]), .vga(vif1));

  vga_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) d2 (.clk_i(clk), .rst_i(rst[2]), .vga(vif2));

  // Model parameters, one column per DUT.
  int ha [3] = '{640, 40, 4};
  int hf [3] = '{16, 4, 1};
  int hs [3] = '{96, 8, 1};
  int hb [3] = '{48, 4, 1};
  int va [3] = '{480, 30, 3};
  int vf [3] = '{10, 3, 1};
  int vs [3] = '{2, 2, 1};
  int vb [3] = '{33, 5, 1};
  bit hp [3] = '{1'b0, 1'b0, 1'b1};
  bit vp [3] = '{1'b0, 1'b0, 1'b1};

  int mx [3];
  int my [3];
  int mf [3];

  int n_checks = 0;
  int n_pass   = 0;

  // Layout: {pad[39:33], frame[32:25], x[24:15], y[14:5], de, hsync, vsync, nv, nf}
  function automatic logic [39:0] pack(int f, int x, int y, bit de, bit hsy, bit vsy,
                                       bit nv, bit nf);
    return {7'd0, 8'(f), 10'(x), 10'(y), de, hsy, vsy, nv, nf};
  endfunction

  logic [39:0] obs [3];
  logic [7:0]  fr0, fr1, fr2;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign fr0 = vif0.frame_o;
  assign fr1 = vif1.frame_o;
  assign fr2 = vif2.frame_o;
`else
  assign fr0 = 8'd0;
  assign fr1 = 8'd0;
  assign fr2 = 8'd0;
`endif
  assign obs[0] = {7'd0, fr0, vif0.x_o, vif0.y_o, vif0.de_o, vif0.hsync_o, vif0.vsync_o,
                   vif0.next_vertical_o, vif0.next_frame_o};
  assign obs[1] = {7'd0, fr1, vif1.x_o, vif1.y_o, vif1.de_o, vif1.hsync_o, vif1.vsync_o,
                   vif1.next_vertical_o, vif1.next_frame_o};
  assign obs[2] = {7'd0, fr2, vif2.x_o, vif2.y_o, vif2.de_o, vif2.hsync_o, vif2.vsync_o,
                   vif2.next_vertical_o, vif2.next_frame_o};

  task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // Expected outputs from the raster rules applied to the model position.
  function automatic logic [39:0] expect_vec(int k);
    int ht, vt, x, y, sb, vsb;
    bit de, hsy, vsy, nv, nf;
    ht  = ha[k] + hf[k] + hs[k] + hb[k];
    vt  = va[k] + vf[k] + vs[k] + vb[k];
    x   = mx[k];
    y   = my[k];
    sb  = ha[k] + hf[k];
    vsb = va[k] + vf[k];
    de  = (x < ha[k]) && (y < va[k]);
    hsy = (x >= sb && x < sb + hs[k]) ? hp[k] : !hp[k];
    vsy = (y >= vsb && y < vsb + vs[k]) ? vp[k] : !vp[k];
    nv  = (x == ht - 1);
    nf  = nv && (y == vt - 1);
    return pack(HAS_FRAME ? mf[k] : 0, x, y, de, hsy, vsy, nv, nf);
  endfunction

  task automatic model_advance(int k);
    int ht, vt;
    ht = ha[k] + hf[k] + hs[k] + hb[k];
    vt = va[k] + vf[k] + vs[k] + vb[k];
    if (rst[k]) begin
      mx[k] = 0; my[k] = 0; mf[k] = 0;
    end else if (mx[k] == ht - 1) begin
      mx[k] = 0;
      if (my[k] == vt - 1) begin
        my[k] = 0;
        mf[k] = (mf[k] + 1) % 256;
      end else begin
        my[k] = my[k] + 1;
      end
    end else begin
      mx[k] = mx[k] + 1;
    end
  endtask

  int cyc = 0;

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_advance(k);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++)
      check_val($sformatf("cycle d%0d c%0d", k, cyc), obs[k], expect_vec(k));
  endtask

  initial begin
    int hrun, hs_first, vrun, vs_first;
    bit seen_wrap, found;
    logic [7:0] prev_f2;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; mx[k] = 0; my[k] = 0; mf[k] = 0;
    end
    step();
    for (int k = 0; k < 3; k++)
      check_val($sformatf("rst_state d%0d", k), obs[k],
                pack(0, 0, 0, 1'b1, !hp[k], !vp[k], 1'b0, 1'b0));

    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    hrun = 0; hs_first = -1; vrun = 0; vs_first = -1;
    seen_wrap = 1'b0; prev_f2 = obs[2][32:25];
    for (int i = 0; i < 11000; i++) begin
      step();
      if (!obs[0][3]) hrun++;
      else begin
        if (hrun > 0 && hs_first < 0) hs_first = hrun;
        hrun = 0;
      end
      if (!obs[1][2]) vrun++;
      else begin
        if (vrun > 0 && vs_first < 0) vs_first = vrun;
        vrun = 0;
      end
      if (prev_f2 == 8'd255 && obs[2][32:25] == 8'd0) seen_wrap = 1'b1;
      prev_f2 = obs[2][32:25];
    end
    check_val("hsync_run_d0", 40'(hs_first), 40'd96);
    check_val("vsync_run_d1", 40'(vs_first), 40'd112);
    if (HAS_FRAME) check_val("frame_wrap_d2", 40'(seen_wrap), 40'd1);

    // Mid-frame reset on d1 at (30,20).
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mx[1] == 30 && my[1] == 20) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_val("mid_rst_reach", 40'(found), 40'd1);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    check_val("mid_rst_d1", obs[1], pack(0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

    // Random resets against the running model.
    for (int i = 0; i < 30000; i++) begin
      for (int k = 0; k < 3; k++) rst[k] = ($urandom_range(0, 1999) == 0);
      step();
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
